// File: rtl/ppu_pkg.sv
// Shared encodings for the PPU scaler: processing modes, FSM states and
// counter-width helpers used by the top and the line store.
package ppu_pkg;

  localparam logic [2:0] MODE_PASS    = 3'd0;
  localparam logic [2:0] MODE_INVERT  = 3'd1;
  localparam logic [2:0] MODE_HDOUBLE = 3'd2;
  localparam logic [2:0] MODE_VDOUBLE = 3'd3;

  typedef enum logic [1:0] {
    STREAM      = 2'd0,
    REPEAT_PIX  = 2'd1,
    REPLAY_LINE = 2'd2
  } state_t;

  // Modes 4-7 are reserved and behave as plain pass-through.
  function automatic logic [2:0] mode_decode(input logic [2:0] m);
    return m[2] ? MODE_PASS : m;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ppu_line_store.sv
// One-line pixel buffer: single synchronous write port, combinational read.
module ppu_line_store
  import ppu_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LINE_LEN = 32
) (
  input  logic                        clk,
  input  logic                        i_we,
  input  logic [cnt_w(LINE_LEN)-1:0]  i_waddr,
  input  logic [DATA_W-1:0]           i_wdata,
  input  logic [cnt_w(LINE_LEN)-1:0]  i_raddr,
  output logic [DATA_W-1:0]           o_rdata
);

  logic [DATA_W-1:0] r_mem [LINE_LEN];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ppu_scaler.sv
// Streaming pixel scaler: pass, invert, horizontal doubling and vertical
// doubling (line replay from a line store), with frame sync and EOL/EOF marks.
module ppu_scaler
  import ppu_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned LINE_LEN    = 32,
  parameter int unsigned FRAME_LINES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync,
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy
);

  localparam int unsigned HW = cnt_w(LINE_LEN);
  localparam int unsigned VW = cnt_w(FRAME_LINES);
  localparam logic [HW-1:0] H_LAST = HW'(LINE_LEN - 1);
  localparam logic [VW-1:0] V_LAST = VW'(FRAME_LINES - 1);

  state_t            r_state;
  logic [HW-1:0]     r_h;
  logic [HW-1:0]     r_rd;
  logic [VW-1:0]     r_v;
  logic [2:0]        r_mode;
  logic [DATA_W-1:0] r_out_data;
  logic [DATA_W-1:0] r_pix;
  logic              r_out_valid;
  logic              r_out_eol;
  logic              r_out_eof;
  logic              r_rep_eol;
  logic              r_rep_eof;
  logic              r_rd_last;

  logic              w_out_free;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_line_start;
  logic [2:0]        w_mode;
  logic              w_h_last;
  logic              w_v_last;
  logic              w_rd_end;
  logic [VW-1:0]     w_v_next;
  logic              w_store_we;
  logic [DATA_W-1:0] w_rd_data;

  assign w_out_free   = !r_out_valid || out_ready;
  assign in_ready     = (r_state == STREAM) && w_out_free && !sync && !rst;
  assign w_in_fire    = in_valid && in_ready;
  assign w_out_fire   = r_out_valid && out_ready;
  assign w_line_start = (r_state == STREAM) && (r_h == '0);
  // The first pixel of a line sees the live mode, the rest the latched copy.
  assign w_mode       = mode_decode(w_line_start ? mode : r_mode);
  assign w_h_last     = (r_h == H_LAST);
  assign w_v_last     = (r_v == V_LAST);
  assign w_rd_end     = (r_rd == H_LAST);
  assign w_v_next     = w_v_last ? '0 : r_v + 1'b1;
  assign w_store_we   = w_in_fire && (w_mode == MODE_VDOUBLE);

  ppu_line_store #(
    .DATA_W   (DATA_W),
    .LINE_LEN (LINE_LEN)
  ) u_line_store (
    .clk     (clk),
    .i_we    (w_store_we),
    .i_waddr (r_h),
    .i_wdata (in_data),
    .i_raddr (r_rd),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= STREAM;
      r_h         <= '0;
      r_rd        <= '0;
      r_v         <= '0;
      r_mode      <= MODE_PASS;
      r_out_data  <= '0;
      r_pix       <= '0;
      r_out_valid <= 1'b0;
      r_out_eol   <= 1'b0;
      r_out_eof   <= 1'b0;
      r_rep_eol   <= 1'b0;
      r_rep_eof   <= 1'b0;
      r_rd_last   <= 1'b0;
    end else if (sync) begin
      r_state     <= STREAM;
      r_h         <= '0;
      r_rd        <= '0;
      r_v         <= '0;
      r_out_valid <= 1'b0;
      r_out_eol   <= 1'b0;
      r_out_eof   <= 1'b0;
      r_rd_last   <= 1'b0;
    end else begin
      if (w_line_start) r_mode <= mode;
      case (r_state)
        STREAM: begin
          if (w_in_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data;
            r_out_eol   <= w_h_last;
            r_out_eof   <= w_h_last && w_v_last;
            r_h         <= w_h_last ? '0 : r_h + 1'b1;
            if (w_h_last && (w_mode != MODE_VDOUBLE)) r_v <= w_v_next;
            case (w_mode)
              MODE_INVERT: r_out_data <= ~in_data;
              MODE_HDOUBLE: begin
                r_out_eol <= 1'b0;
                r_out_eof <= 1'b0;
                r_pix     <= in_data;
                r_rep_eol <= w_h_last;
                r_rep_eof <= w_h_last && w_v_last;
                r_state   <= REPEAT_PIX;
              end
              MODE_VDOUBLE: begin
                // Pass-through copy never carries EOF; the replayed line does.
                r_out_eof <= 1'b0;
                if (w_h_last) begin
                  r_rd      <= '0;
                  r_rd_last <= 1'b0;
                  r_state   <= REPLAY_LINE;
                end
              end
              default: ;
            endcase
          end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
          end
        end
        REPEAT_PIX: begin
          if (w_out_fire) begin
            r_out_data <= r_pix;
            r_out_eol  <= r_rep_eol;
            r_out_eof  <= r_rep_eof;
            r_state    <= STREAM;
          end
        end
        REPLAY_LINE: begin
          if (w_out_free) begin
            if (r_rd_last) begin
              r_out_valid <= 1'b0;
              r_rd_last   <= 1'b0;
              r_v         <= w_v_next;
              r_state     <= STREAM;
            end else begin
              r_out_valid <= 1'b1;
              r_out_data  <= w_rd_data;
              r_out_eol   <= w_rd_end;
              r_out_eof   <= w_rd_end && w_v_last;
              r_rd_last   <= w_rd_end;
              r_rd        <= w_rd_end ? '0 : r_rd + 1'b1;
            end
          end
        end
        default: r_state <= STREAM;
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_eol   = r_out_eol;
  assign out_eof   = r_out_eof;
  assign busy      = (r_state != STREAM) || r_out_valid;

endmodule

// File: tb/tb_ppu_scaler.sv
// Directed bench for ppu_scaler: two instances (2-line and 1-line frames)
// share all inputs and run in lockstep; expected values are hand-derived.
module tb_ppu_scaler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, out_eol, out_eof, busy;
  logic [7:0] out_data;
  logic       b_in_ready, b_out_valid, b_out_eol, b_out_eof, b_busy;
  logic [7:0] b_out_data;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] pix   [16];
  logic [7:0] exp_d [16];
  logic       exp_eol  [16];
  logic       exp_eofa [16];
  logic       exp_eofb [16];
  int         in_cyc   [16];

  always #5 clk = ~clk;

  ppu_scaler #(.DATA_W(8), .LINE_LEN(4), .FRAME_LINES(2)) u_dut (
    .clk(clk), .rst(rst), .sync(sync), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_eol(out_eol), .out_eof(out_eof), .busy(busy)
  );

  ppu_scaler #(.DATA_W(8), .LINE_LEN(4), .FRAME_LINES(1)) u_dut_b (
    .clk(clk), .rst(rst), .sync(sync), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_eol(b_out_eol), .out_eof(b_out_eof), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 with sync released.
  task automatic do_sync();
    sync     = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    sync = 1'b0;
  endtask

  task automatic run_stream(input int n_in, input int n_out, input bit lat, input bit hd);
    int in_idx  = 0;
    int out_idx = 0;
    int cyc     = 0;
    while (out_idx < n_out && cyc < 200) begin
      out_ready = 1'b1;
      in_valid  = (in_idx < n_in);
      if (in_idx < n_in) in_data = pix[in_idx];
      @(negedge clk);
      if (out_valid) begin
        check("data", out_data, exp_d[out_idx]);
        check("eol", out_eol, exp_eol[out_idx]);
        check("eof", out_eof, exp_eofa[out_idx]);
        check("b_data", b_out_data, exp_d[out_idx]);
        check("b_eof", b_out_eof, exp_eofb[out_idx]);
        if (lat) check("latency", cyc - in_cyc[out_idx], 1);
        if (hd && (out_idx % 2 == 0)) check("h2_rdy_lo", in_ready, 0);
        out_idx++;
      end
      if (in_valid && in_ready) begin
        in_cyc[in_idx] = cyc;
        in_idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_done", out_idx, n_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_data", out_data, 0);
    check("rst_valid", out_valid, 0);
    check("rst_eol", out_eol, 0);
    check("rst_eof", out_eof, 0);
    check("rst_rdy", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_b", {b_out_data, b_out_valid, b_out_eol, b_out_eof, b_in_ready, b_busy}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Mode 0 pass-through, 1-cycle latency
    mode = 3'd0;
    for (int i = 0; i < 4; i++) begin
      pix[i] = 8'h10 + 8'(i); exp_d[i] = 8'h10 + 8'(i);
      exp_eol[i] = (i == 3); exp_eofa[i] = 1'b0; exp_eofb[i] = (i == 3);
    end
    run_stream(4, 4, 1'b1, 1'b0);

    // Mode 1 invert with output stall
    do_sync();
    mode = 3'd1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h0F;
    @(negedge clk);
    check("inv_rdy0", in_ready, 1);
    @(posedge clk); #1;
    in_data = 8'h33;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_data", out_data, 8'hF0);
      check("stall_valid", out_valid, 1);
      check("stall_rdy", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("inv_eol", out_eol, 0);
    check("unstall_rdy", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("inv_data2", out_data, 8'hCC);
    @(posedge clk); #1;

    // Mode 2 horizontal doubling
    do_sync();
    mode = 3'd2;
    for (int i = 0; i < 4; i++) pix[i] = 8'hA1 + 8'(8'h11 * i);
    for (int i = 0; i < 8; i++) begin
      exp_d[i] = pix[i / 2];
      exp_eol[i] = (i == 7); exp_eofa[i] = 1'b0; exp_eofb[i] = (i == 7);
    end
    run_stream(4, 8, 1'b0, 1'b1);

    // Mode 3 vertical doubling over a 2-line frame
    do_sync();
    mode = 3'd3;
    for (int i = 0; i < 8; i++) pix[i] = 8'h20 + 8'(i);
    for (int l = 0; l < 2; l++)
      for (int r = 0; r < 2; r++)
        for (int k = 0; k < 4; k++) begin
          exp_d[l*8 + r*4 + k]    = 8'h20 + 8'(l*4 + k);
          exp_eol[l*8 + r*4 + k]  = (k == 3);
          exp_eofa[l*8 + r*4 + k] = (l == 1) && (r == 1) && (k == 3);
          exp_eofb[l*8 + r*4 + k] = (r == 1) && (k == 3);
        end
    run_stream(8, 16, 1'b0, 1'b0);
    @(negedge clk);
    check("v2_idle_busy", busy, 0);
    check("v2_idle_rdy", in_ready, 1);
    @(posedge clk); #1;

    // Sync during line replay drops the pending pixel and restarts counters
    do_sync();
    mode = 3'd3;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h40 + 8'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    sync = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    check("rpl_data", out_data, 8'h40);
    check("rpl_valid", out_valid, 1);
    check("sync_rdy", in_ready, 0);
    @(posedge clk); #1;
    sync = 1'b0;
    out_ready = 1'b1;
    mode = 3'd0;
    @(negedge clk);
    check("sync_valid", out_valid, 0);
    check("sync_busy", busy, 0);
    check("sync_rdy_after", in_ready, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      pix[i] = 8'h50 + 8'(i); exp_d[i] = 8'h50 + 8'(i);
      exp_eol[i] = (i == 3) || (i == 7); exp_eofa[i] = (i == 7);
      exp_eofb[i] = (i == 3) || (i == 7);
    end
    run_stream(8, 8, 1'b1, 1'b0);

    // Reset mid-line in mode 2
    do_sync();
    mode = 3'd2;
    in_valid = 1'b1;
    in_data  = 8'hA1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("mrst_data", out_data, 0);
    check("mrst_valid", out_valid, 0);
    check("mrst_eol", out_eol, 0);
    check("mrst_eof", out_eof, 0);
    check("mrst_rdy", in_ready, 0);
    check("mrst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) pix[i] = 8'hA1 + 8'(8'h11 * i);
    for (int i = 0; i < 8; i++) begin
      exp_d[i] = pix[i / 2];
      exp_eol[i] = (i == 7); exp_eofa[i] = 1'b0; exp_eofb[i] = (i == 7);
    end
    run_stream(4, 8, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
